// File: rtl/and_gate.sv
// Bitwise AND of two operands with a combinational result and registered copies
// (value, reduction-AND, reduction-OR); optional saturating hit counter under AND_GATE_STATS_EN.
module and_gate #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             all_q,
  output logic             any_q
`ifdef AND_GATE_STATS_EN
  ,
  output logic [15:0]      hit_cnt
`endif
);

  logic [WIDTH-1:0] and_d;
  logic             all_d;
  logic             any_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_and_bit
      assign and_d[gi] = a[gi] & b[gi];
    end
  endgenerate

  // y is purely combinational so X/Z propagate with normal AND semantics.
  assign y     = and_d;
  assign all_d = &and_d;
  assign any_d = |and_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      all_q <= 1'b0;
      any_q <= 1'b0;
    end else if (en) begin
      y_q   <= and_d;
      all_q <= all_d;
      any_q <= any_d;
    end
  end

`ifdef AND_GATE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] hit_cnt_d;

  // Counts loads where every result bit is set; sticks at all ones until reset.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (en && all_d && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Randomized self-checking bench for and_gate (WIDTH=8 and WIDTH=1 instances);
// hit counter checks are active when AND_GATE_STATS_EN is defined.
module tb_and_gate;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] a8, b8;
  logic       a1, b1;
  logic [7:0] y8, yq8;
  logic       all8, any8;
  logic       y1, yq1, all1, any1;
`ifdef AND_GATE_STATS_EN
  logic [15:0] hit8, hit1;
`endif

  int n_cmp;
  int n_bad;

  // Reference state
  logic [7:0] m_yq8;
  logic       m_all8, m_any8;
  logic       m_yq1, m_all1, m_any1;
  int         m_hit;

  and_gate #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .en(en),
    .y(y8), .y_q(yq8), .all_q(all8), .any_q(any8)
`ifdef AND_GATE_STATS_EN
    , .hit_cnt(hit8)
`endif
  );

  and_gate #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .en(en),
    .y(y1), .y_q(yq1), .all_q(all1), .any_q(any1)
`ifdef AND_GATE_STATS_EN
    , .hit_cnt(hit1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Elementwise product of bits, then count set bits: full/any derive from the count.
  function automatic logic [7:0] ref_and8(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ((int'(x[i]) * int'(z[i])) == 1);
    return r;
  endfunction

  function automatic int popcount8(input logic [7:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".yq8"},  64'(yq8),  64'(m_yq8));
    check({tag, ".all8"}, 64'(all8), 64'(m_all8));
    check({tag, ".any8"}, 64'(any8), 64'(m_any8));
    check({tag, ".yq1"},  64'(yq1),  64'(m_yq1));
    check({tag, ".all1"}, 64'(all1), 64'(m_all1));
    check({tag, ".any1"}, 64'(any1), 64'(m_any1));
    check({tag, ".impl"}, 64'(all8 & ~any8), 64'(0));
`ifdef AND_GATE_STATS_EN
    check({tag, ".hit"},  64'(hit8), 64'(m_hit));
`endif
  endtask

  // Drive on the falling edge, check y, then check registered state 1 ns after the rising edge.
  task automatic apply(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic a1v, input logic b1v, input logic env, input logic rstv);
    logic [7:0] p;
    int         pc;
    @(negedge clk);
    a8 = av; b8 = bv; a1 = a1v; b1 = b1v; en = env; rst = rstv;
    #1;
    p  = ref_and8(av, bv);
    pc = popcount8(p);
    check({tag, ".y8"}, 64'(y8), 64'(p));
    check({tag, ".y1"}, 64'(y1), 64'(a1v && b1v));
    @(posedge clk);
    if (rstv) begin
      m_yq8 = 8'h00; m_all8 = 1'b0; m_any8 = 1'b0;
      m_yq1 = 1'b0;  m_all1 = 1'b0; m_any1 = 1'b0;
      m_hit = 0;
    end else if (env) begin
      m_yq8  = p;
      m_all8 = (pc == 8);
      m_any8 = (pc > 0);
      m_yq1  = a1v && b1v;
      m_all1 = m_yq1;
      m_any1 = m_yq1;
      if (pc == 8 && m_hit < 65535) m_hit++;
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       seq_a [4];
    logic       seq_b [4];
    logic       seq_y [4];
    n_cmp = 0; n_bad = 0;
    m_yq8 = 'x; m_all8 = 'x; m_any8 = 'x; m_yq1 = 'x; m_all1 = 'x; m_any1 = 'x; m_hit = 0;
    rst = 1'b1; en = 1'b0; a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;

    apply("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single-bit combinational walk: a=0,b=0 -> a=1 -> b=1 -> a=0
    seq_a = '{1'b0, 1'b1, 1'b1, 1'b0};
    seq_b = '{1'b0, 1'b0, 1'b1, 1'b1};
    seq_y = '{1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1 = seq_a[i]; b1 = seq_b[i];
      #1;
      check($sformatf("walk%0d.y1", i), 64'(y1), 64'(seq_y[i]));
      #9;
    end

    apply("f0_3c", 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    check("f0_3c.const_y",   64'(y8),   64'h30);
    check("f0_3c.const_yq",  64'(yq8),  64'h30);
    check("f0_3c.const_all", 64'(all8), 64'h0);
    check("f0_3c.const_any", 64'(any8), 64'h1);

    apply("hold", 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    check("hold.const_yq", 64'(yq8), 64'h30);
    apply("load_ff", 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
    check("load_ff.const_yq",  64'(yq8),  64'hFF);
    check("load_ff.const_all", 64'(all8), 64'h1);

    apply("rst_en", 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_en.const_y",  64'(y8),  64'hFF);
    check("rst_en.const_yq", 64'(yq8), 64'h00);
    apply("post_rst", 8'h81, 8'hC1, 1'b1, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin ra = 8'hFF; rb = 8'hFF; end
      apply($sformatf("rnd%0d", i), ra, rb, 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end

`ifdef AND_GATE_STATS_EN
    apply("sat_rst", 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    repeat (65540) @(posedge clk);
    #1;
    check("sat.hit", 64'(hit8), 64'hFFFF);
    apply("sat_clear", 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
    check("sat_clear.const_hit", 64'(hit8), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
